// File: rtl/interrupt_controller_mod_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : interrupt_controller_mod_pkg
//  Purpose  : Shared definitions for the interrupt controller: source bit
//             indices, default vector layout, FSM state encoding and the
//             vector address helper.
//  Revision : 1.0 - initial release
// ============================================================================
package interrupt_controller_mod_pkg;

    // Source bit positions in IE / IF
    localparam int SRC_VBLANK = 0;
    localparam int SRC_STAT   = 1;
    localparam int SRC_TIMER  = 2;
    localparam int SRC_SERIAL = 3;
    localparam int SRC_JOYPAD = 4;

    // Default vector layout
    localparam logic [15:0] DEF_VEC_BASE   = 16'h0040;
    localparam int          DEF_VEC_STRIDE = 8;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } ic_state_t;

    // Vector address for a source index; the sum is kept to 16 bits
    function automatic logic [15:0] vec_calc(input logic [15:0] base,
                                             input int          stride,
                                             input logic [7:0]  idx);
        logic [15:0] w_offs;
        w_offs = 16'(stride * int'(idx));
        return base + w_offs;
    endfunction

endpackage : interrupt_controller_mod_pkg
`default_nettype wire

// File: rtl/int_priority_enc_mod.sv
`default_nettype none
// ============================================================================
//  Module   : int_priority_enc_mod
//  Purpose  : Lowest-index-first priority encoder over the pending vector.
//  Revision : 1.0 - initial release
// ============================================================================
module int_priority_enc_mod #(
    parameter int NUM_SRC = 5
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [7:0]         index,
    output logic               valid
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        index = 8'd0;
        valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = 8'(i);
                valid = 1'b1;
            end
        end
    end

endmodule : int_priority_enc_mod
`default_nettype wire

// File: rtl/interrupt_controller_mod.sv
`default_nettype none
// ============================================================================
//  Module   : interrupt_controller_mod
//  Purpose  : IE/IF registers, IME with delayed EI, request/service handshake
//             with the control unit and vector address generation.
//  Revision : 1.0 - initial release
// ============================================================================
module interrupt_controller_mod
    import interrupt_controller_mod_pkg::*;
#(
    parameter int          NUM_SRC    = 5,
    parameter logic [15:0] VEC_BASE   = DEF_VEC_BASE,
    parameter int          VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               ie_wr,
    input  logic               if_wr,
    input  logic [7:0]         wr_data,
    output logic [7:0]         ie_out,
    output logic [7:0]         if_out,
    input  logic               ime_set,
    input  logic               ime_clear,
    input  logic               reti_en,
    input  logic               inst_done,
    input  logic               int_ack,
    input  logic               service_done,
    output logic               int_pending,
    output logic               int_wake,
    output logic [15:0]        vector_addr,
    output logic               int_active
);

    logic [7:0]         r_ie;
    logic [NUM_SRC-1:0] r_if;
    logic [NUM_SRC-1:0] r_irq_prev;
    logic               r_ime;
    logic               r_ei_arm;
    ic_state_t          r_state;
    logic [15:0]        r_vec;

    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_pending;
    logic               w_any;
    logic [7:0]         w_enc_idx;
    logic               w_enc_valid;
    logic               w_ack_take;
    logic [NUM_SRC-1:0] w_ack_mask;
    logic [NUM_SRC-1:0] w_if_nxt;
    logic               w_ime_nxt;
    logic               w_arm_nxt;
    logic [7:0]         w_if_out;

    assign w_edge    = irq_src & ~r_irq_prev;
    assign w_pending = r_ie[NUM_SRC-1:0] & r_if;

    int_priority_enc_mod #(
        .NUM_SRC (NUM_SRC)
    ) u_prio (
        .req   (w_pending),
        .index (w_enc_idx),
        .valid (w_enc_valid)
    );

    assign w_any = w_enc_valid;

    // An ack only counts while a request is actually outstanding
    assign w_ack_take = (r_state == ST_REQ) && int_ack && w_any;
    assign w_ack_mask = w_ack_take ? (NUM_SRC'(1) << w_enc_idx) : '0;

    // IF next value: peripheral edge beats ack clear, which beats a bus write
    always_comb begin
        w_if_nxt = if_wr ? wr_data[NUM_SRC-1:0] : r_if;
        w_if_nxt = w_if_nxt & ~w_ack_mask;
        w_if_nxt = w_if_nxt | w_edge;
    end

    // IME next value: DI/ack win; EI takes effect one instruction late, RETI at once
    always_comb begin
        w_ime_nxt = r_ime;
        w_arm_nxt = r_ei_arm;
        if (ime_clear || w_ack_take) begin
            w_ime_nxt = 1'b0;
            w_arm_nxt = 1'b0;
        end else begin
            if (reti_en) begin
                w_ime_nxt = 1'b1;
            end
            if (r_ei_arm && inst_done) begin
                w_ime_nxt = 1'b1;
                w_arm_nxt = 1'b0;
            end
            if (ime_set) begin
                w_arm_nxt = 1'b1;
            end
        end
    end

    // Upper IF bits read back as ones
    always_comb begin
        w_if_out               = 8'hFF;
        w_if_out[NUM_SRC-1:0]  = r_if;
    end

    // Register file, edge history and IME state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ie       <= 8'h00;
            r_if       <= '0;
            r_irq_prev <= '0;
            r_ime      <= 1'b0;
            r_ei_arm   <= 1'b0;
        end else begin
            if (ie_wr) begin
                r_ie <= wr_data;
            end
            r_if       <= w_if_nxt;
            r_irq_prev <= irq_src;
            r_ime      <= w_ime_nxt;
            r_ei_arm   <= w_arm_nxt;
        end
    end

    // Request / service handshake with the control unit and vector latch.
    // IDLE looks at next-cycle IME so a request appears together with IME.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_vec   <= VEC_BASE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ime_nxt && w_any) begin
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!w_any) begin
                        r_state <= ST_IDLE;
                    end else if (int_ack) begin
                        r_state <= ST_SERVICE;
                        r_vec   <= vec_calc(VEC_BASE, VEC_STRIDE, w_enc_idx);
                    end
                end
                ST_SERVICE: begin
                    if (service_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ie_out      = r_ie;
    assign if_out      = w_if_out;
    assign int_wake    = w_any;
    assign int_pending = (r_state == ST_REQ) && w_any;
    assign int_active  = (r_state == ST_SERVICE);
    assign vector_addr = r_vec;

endmodule : interrupt_controller_mod
`default_nettype wire

// File: tb/tb_interrupt_controller_mod.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interrupt_controller_mod
//  Purpose  : Directed self-checking bench for interrupt_controller_mod.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller_mod;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  irq_src;
    logic        ie_wr, if_wr;
    logic [7:0]  wr_data;
    logic [7:0]  ie_out, if_out;
    logic        ime_set, ime_clear, reti_en, inst_done;
    logic        int_ack, service_done;
    logic        int_pending, int_wake, int_active;
    logic [15:0] vector_addr;

    int checks = 0;
    int errors = 0;

    interrupt_controller_mod dut (
        .clock        (clock),
        .reset        (reset),
        .irq_src      (irq_src),
        .ie_wr        (ie_wr),
        .if_wr        (if_wr),
        .wr_data      (wr_data),
        .ie_out       (ie_out),
        .if_out       (if_out),
        .ime_set      (ime_set),
        .ime_clear    (ime_clear),
        .reti_en      (reti_en),
        .inst_done    (inst_done),
        .int_ack      (int_ack),
        .service_done (service_done),
        .int_pending  (int_pending),
        .int_wake     (int_wake),
        .vector_addr  (vector_addr),
        .int_active   (int_active)
    );

    always #5 clock = ~clock;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ie_wr = 0; if_wr = 0; wr_data = 8'h00;
        ime_set = 0; ime_clear = 0; reti_en = 0; inst_done = 0;
        int_ack = 0; service_done = 0;
    endtask

    task automatic test_reset();
        reset = 1; irq_src = 5'h00; idle_inputs();
        tick(); tick();
        reset = 0;
        checks++; if (ie_out !== 8'h00) begin errors++; $display("FAIL reset_ie: got %h want 00", ie_out); end
        checks++; if (if_out !== 8'hE0) begin errors++; $display("FAIL reset_if: got %h want E0", if_out); end
        checks++; if (int_pending !== 1'b0 || int_active !== 1'b0 || int_wake !== 1'b0) begin
            errors++; $display("FAIL reset_flags: pend=%b act=%b wake=%b want 0 0 0", int_pending, int_active, int_wake); end
        checks++; if (vector_addr !== 16'h0040) begin errors++; $display("FAIL reset_vec: got %h want 0040", vector_addr); end
    endtask

    task automatic test_single_source();
        ie_wr = 1; wr_data = 8'h1F; tick(); ie_wr = 0;
        checks++; if (ie_out !== 8'h1F) begin errors++; $display("FAIL ie_write: got %h want 1F", ie_out); end
        reti_en = 1; tick(); reti_en = 0;
        irq_src = 5'b00100; tick();
        checks++; if (if_out !== 8'hE4) begin errors++; $display("FAIL timer_if: got %h want E4", if_out); end
        tick(); irq_src = 5'b00000;
        checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL timer_pending: got %b want 1", int_pending); end
        int_ack = 1; tick(); int_ack = 0;
        checks++; if (vector_addr !== 16'h0050) begin errors++; $display("FAIL timer_vec: got %h want 0050", vector_addr); end
        checks++; if (if_out !== 8'hE0 || int_active !== 1'b1) begin
            errors++; $display("FAIL timer_ack: if=%h act=%b want E0 1", if_out, int_active); end
        service_done = 1; tick(); service_done = 0;
        checks++; if (int_active !== 1'b0) begin errors++; $display("FAIL timer_done: act=%b want 0", int_active); end
        // IME was cleared by the ack, so a fresh pending flag must not request
        if_wr = 1; wr_data = 8'h01; tick(); if_wr = 0;
        tick(); tick();
        checks++; if (int_pending !== 1'b0 || int_wake !== 1'b1) begin
            errors++; $display("FAIL ime_cleared: pend=%b wake=%b want 0 1", int_pending, int_wake); end
        if_wr = 1; wr_data = 8'h00; tick(); if_wr = 0;
    endtask

    task automatic test_priority();
        if_wr = 1; wr_data = 8'h1F; tick(); if_wr = 0;
        checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL prio_noime: got %b want 0", int_pending); end
        reti_en = 1; tick(); reti_en = 0;
        checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL prio_reti_req: got %b want 1", int_pending); end
        int_ack = 1; tick(); int_ack = 0;
        checks++; if (vector_addr !== 16'h0040 || if_out !== 8'hFE) begin
            errors++; $display("FAIL prio_first: vec=%h if=%h want 0040 FE", vector_addr, if_out); end
        service_done = 1; tick(); service_done = 0;
        checks++; if (int_pending !== 1'b0 || int_active !== 1'b0) begin
            errors++; $display("FAIL prio_between: pend=%b act=%b want 0 0", int_pending, int_active); end
        reti_en = 1; tick(); reti_en = 0;
        checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL prio_second_req: got %b want 1", int_pending); end
        int_ack = 1; tick(); int_ack = 0;
        checks++; if (vector_addr !== 16'h0048 || if_out !== 8'hFC) begin
            errors++; $display("FAIL prio_second: vec=%h if=%h want 0048 FC", vector_addr, if_out); end
        service_done = 1; tick(); service_done = 0;
        if_wr = 1; wr_data = 8'h00; tick(); if_wr = 0;
    endtask

    task automatic test_ei_delay();
        ie_wr = 1; if_wr = 1; wr_data = 8'h01; tick(); ie_wr = 0; if_wr = 0;
        checks++; if (int_wake !== 1'b1 || int_pending !== 1'b0) begin
            errors++; $display("FAIL ei_wake: wake=%b pend=%b want 1 0", int_wake, int_pending); end
        // EI on an instruction boundary waits for the following boundary
        ime_set = 1; inst_done = 1; tick(); ime_set = 0; inst_done = 0;
        tick();
        checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL ei_armed: got %b want 0", int_pending); end
        inst_done = 1; tick(); inst_done = 0;
        checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL ei_enabled: got %b want 1", int_pending); end
    endtask

    task automatic test_cancel();
        if_wr = 1; wr_data = 8'h00; tick(); if_wr = 0;
        checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL cancel_drop: got %b want 0", int_pending); end
        tick();
        int_ack = 1; tick(); int_ack = 0;
        checks++; if (int_active !== 1'b0 || vector_addr !== 16'h0048) begin
            errors++; $display("FAIL cancel_ack_ignored: act=%b vec=%h want 0 0048", int_active, vector_addr); end
    endtask

    task automatic test_edge_vs_ack();
        irq_src = 5'b00001; tick();
        checks++; if (if_out !== 8'hE1) begin errors++; $display("FAIL edge_set: got %h want E1", if_out); end
        irq_src = 5'b00000; tick();
        checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL edge_req: got %b want 1", int_pending); end
        irq_src = 5'b00001; int_ack = 1; if_wr = 1; wr_data = 8'h00; tick();
        int_ack = 0; if_wr = 0; irq_src = 5'b00000;
        checks++; if (if_out !== 8'hE1 || int_active !== 1'b1 || vector_addr !== 16'h0040) begin
            errors++; $display("FAIL edge_wins: if=%h act=%b vec=%h want E1 1 0040", if_out, int_active, vector_addr); end
    endtask

    task automatic test_reset_in_service();
        service_done = 1; ie_wr = 1; wr_data = 8'h08; tick(); service_done = 0; ie_wr = 0;
        irq_src = 5'b01000; tick(); irq_src = 5'b00000;
        reti_en = 1; tick(); reti_en = 0;
        int_ack = 1; tick(); int_ack = 0;
        checks++; if (vector_addr !== 16'h0058 || int_active !== 1'b1) begin
            errors++; $display("FAIL serial_vec: vec=%h act=%b want 0058 1", vector_addr, int_active); end
        reset = 1; tick(); reset = 0;
        checks++; if (ie_out !== 8'h00 || if_out !== 8'hE0) begin
            errors++; $display("FAIL rst_svc_regs: ie=%h if=%h want 00 E0", ie_out, if_out); end
        checks++; if (int_active !== 1'b0 || vector_addr !== 16'h0040) begin
            errors++; $display("FAIL rst_svc_state: act=%b vec=%h want 0 0040", int_active, vector_addr); end
        tick();
        checks++; if (int_pending !== 1'b0 || int_wake !== 1'b0) begin
            errors++; $display("FAIL rst_svc_quiet: pend=%b wake=%b want 0 0", int_pending, int_wake); end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_priority();
        test_ei_delay();
        test_cancel();
        test_edge_vs_ack();
        test_reset_in_service();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_interrupt_controller_mod
`default_nettype wire
